// File: rtl/uart_rx_points_parser.sv
// uart_rx_points_parser: parses the 37-byte "ST" + 8x(H,V) + "END" point
// frame from a UART byte stream, publishes all points atomically on a good
// frame and flags frames that end in a bad trailer or stall mid-frame.
module uart_rx_points_parser #(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        RX_DV,
    input  logic [7:0]  RX_BYTE,
    output logic [15:0] POINTS_H_0,
    output logic [15:0] POINTS_H_1,
    output logic [15:0] POINTS_H_2,
    output logic [15:0] POINTS_H_3,
    output logic [15:0] POINTS_H_4,
    output logic [15:0] POINTS_H_5,
    output logic [15:0] POINTS_H_6,
    output logic [15:0] POINTS_H_7,
    output logic [15:0] POINTS_V_0,
    output logic [15:0] POINTS_V_1,
    output logic [15:0] POINTS_V_2,
    output logic [15:0] POINTS_V_3,
    output logic [15:0] POINTS_V_4,
    output logic [15:0] POINTS_V_5,
    output logic [15:0] POINTS_V_6,
    output logic [15:0] POINTS_V_7,
    output logic        PKT_VALID,
    output logic        PKT_ERR,
    output logic [15:0] PKT_CNT,
    output logic [7:0]  ERR_CNT
);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    // Expiry fires on the idle cycle that moves the counter to TIMEOUT_CYCLES-1.
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 2);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] HDR_T   = 3'd1;
    localparam logic [2:0] PAYLOAD = 3'd2;
    localparam logic [2:0] TRL_E   = 3'd3;
    localparam logic [2:0] TRL_N   = 3'd4;
    localparam logic [2:0] TRL_D   = 3'd5;

    localparam logic [7:0] C_S = 8'h53;
    localparam logic [7:0] C_T = 8'h54;
    localparam logic [7:0] C_E = 8'h45;
    localparam logic [7:0] C_N = 8'h4E;
    localparam logic [7:0] C_D = 8'h44;

    logic [2:0]           state;
    logic [4:0]           idx;
    logic [TW-1:0]        tcnt;
    logic [31:0][7:0]     shadow;
    logic [7:0][15:0]     pts_h;
    logic [7:0][15:0]     pts_v;

    logic [7:0] trl_exp;
    logic       in_trl;
    logic       mismatch;
    logic       timeout;
    logic       commit;
    logic       err_now;

    // Trailer byte expected in the current state, and the frame-level events.
    always_comb begin
        trl_exp = C_E;
        in_trl  = 1'b0;
        case (state)
            TRL_E:   begin trl_exp = C_E; in_trl = 1'b1; end
            TRL_N:   begin trl_exp = C_N; in_trl = 1'b1; end
            TRL_D:   begin trl_exp = C_D; in_trl = 1'b1; end
            default: begin trl_exp = C_E; in_trl = 1'b0; end
        endcase
        mismatch = RX_DV && in_trl && (RX_BYTE != trl_exp);
        // A byte arriving on the expiry cycle keeps the frame alive.
        timeout  = !RX_DV && (state != IDLE) && (tcnt == T_LAST);
        commit   = RX_DV && (state == TRL_D) && (RX_BYTE == C_D);
        err_now  = mismatch || timeout;
    end

    // Frame state machine and payload capture into the shadow buffer.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            idx    <= '0;
            shadow <= '0;
        end else if (RX_DV) begin
            case (state)
                IDLE:  if (RX_BYTE == C_S) state <= HDR_T;
                HDR_T: begin
                    if (RX_BYTE == C_T) begin
                        state <= PAYLOAD;
                        idx   <= '0;
                    end else if (RX_BYTE != C_S) begin
                        state <= IDLE;
                    end
                end
                PAYLOAD: begin
                    shadow[idx] <= RX_BYTE;
                    idx         <= idx + 5'd1;
                    if (idx == 5'd31) state <= TRL_E;
                end
                TRL_E, TRL_N, TRL_D: begin
                    if (mismatch)
                        state <= (RX_BYTE == C_S) ? HDR_T : IDLE;
                    else if (state == TRL_E)
                        state <= TRL_N;
                    else if (state == TRL_N)
                        state <= TRL_D;
                    else
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end else if (timeout) begin
            state <= IDLE;
        end
    end

    // Inter-byte stall counter: runs only while a frame is in progress.
    always_ff @(posedge CLK) begin
        if (RESET || RX_DV || state == IDLE || timeout)
            tcnt <= '0;
        else
            tcnt <= tcnt + TW'(1);
    end

    // Status pulses, counters and the atomic point update on commit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            PKT_VALID <= 1'b0;
            PKT_ERR   <= 1'b0;
            PKT_CNT   <= '0;
            ERR_CNT   <= '0;
            pts_h     <= '0;
            pts_v     <= '0;
        end else begin
            PKT_VALID <= commit;
            PKT_ERR   <= err_now;
            if (commit) begin
                PKT_CNT <= PKT_CNT + 16'd1;
                for (int i = 0; i < 8; i++) begin
                    pts_h[i] <= {shadow[4*i],     shadow[4*i+1]};
                    pts_v[i] <= {shadow[4*i + 2], shadow[4*i+3]};
                end
            end
            if (err_now && ERR_CNT != 8'hFF)
                ERR_CNT <= ERR_CNT + 8'd1;
        end
    end

    assign POINTS_H_0 = pts_h[0];
    assign POINTS_H_1 = pts_h[1];
    assign POINTS_H_2 = pts_h[2];
    assign POINTS_H_3 = pts_h[3];
    assign POINTS_H_4 = pts_h[4];
    assign POINTS_H_5 = pts_h[5];
    assign POINTS_H_6 = pts_h[6];
    assign POINTS_H_7 = pts_h[7];
    assign POINTS_V_0 = pts_v[0];
    assign POINTS_V_1 = pts_v[1];
    assign POINTS_V_2 = pts_v[2];
    assign POINTS_V_3 = pts_v[3];
    assign POINTS_V_4 = pts_v[4];
    assign POINTS_V_5 = pts_v[5];
    assign POINTS_V_6 = pts_v[6];
    assign POINTS_V_7 = pts_v[7];
endmodule

// File: tb/tb_uart_rx_points_parser.sv
// Bench for uart_rx_points_parser: byte-level frame model checked every cycle,
// a table of frame variants, directed corner sequences and random traffic.
module tb_uart_rx_points_parser;
    localparam int T = 40;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        RX_DV = 1'b0;
    logic [7:0]  RX_BYTE = 8'h00;
    logic [15:0] ph [8];
    logic [15:0] pv [8];
    logic        PKT_VALID, PKT_ERR;
    logic [15:0] PKT_CNT;
    logic [7:0]  ERR_CNT;

    always #5 CLK = ~CLK;

    uart_rx_points_parser #(.TIMEOUT_CYCLES(T)) dut (
        .CLK(CLK), .RESET(RESET), .RX_DV(RX_DV), .RX_BYTE(RX_BYTE),
        .POINTS_H_0(ph[0]), .POINTS_H_1(ph[1]), .POINTS_H_2(ph[2]), .POINTS_H_3(ph[3]),
        .POINTS_H_4(ph[4]), .POINTS_H_5(ph[5]), .POINTS_H_6(ph[6]), .POINTS_H_7(ph[7]),
        .POINTS_V_0(pv[0]), .POINTS_V_1(pv[1]), .POINTS_V_2(pv[2]), .POINTS_V_3(pv[3]),
        .POINTS_V_4(pv[4]), .POINTS_V_5(pv[5]), .POINTS_V_6(pv[6]), .POINTS_V_7(pv[7]),
        .PKT_VALID(PKT_VALID), .PKT_ERR(PKT_ERR), .PKT_CNT(PKT_CNT), .ERR_CNT(ERR_CNT)
    );

    int nvec = 0;
    int nerr = 0;

    // Reference model: position within a frame (0 = hunting for 'S', 1 = got
    // 'S', 2..33 payload, 34..36 trailer) plus idle gap since the last byte.
    int          m_pos, m_gap;
    logic [7:0]  m_buf [32];
    logic [15:0] m_h [8], m_v [8];
    logic [15:0] m_pcnt;
    logic [7:0]  m_ecnt;
    logic        exp_v, exp_e;
    logic [7:0]  trl [3];
    logic        seen_v, seen_e;

    // Frame under construction for send_frame.
    logic [15:0] fh [8], fv [8];
    logic [7:0]  ft [3];
    int          gap_at, gap_len;

    typedef struct {
        string      name;
        logic [7:0] t0, t1, t2;
        int         gat, glen;
        bit         exp_ok;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_gap = 0; m_pcnt = 0; m_ecnt = 0; exp_v = 0; exp_e = 0;
        for (int i = 0; i < 8; i++) begin m_h[i] = 0; m_v[i] = 0; end
    endtask

    task automatic model_err();
        exp_e = 1;
        if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 1;
    endtask

    task automatic model_step(input bit dv, input logic [7:0] b);
        exp_v = 0; exp_e = 0;
        if (dv) begin
            m_gap = 0;
            if (m_pos == 0) begin
                if (b == 8'h53) m_pos = 1;
            end else if (m_pos == 1) begin
                if (b == 8'h54) m_pos = 2;
                else if (b != 8'h53) m_pos = 0;
            end else if (m_pos < 34) begin
                m_buf[m_pos - 2] = b;
                m_pos++;
            end else if (b == trl[m_pos - 34]) begin
                m_pos++;
                if (m_pos == 37) begin
                    for (int i = 0; i < 8; i++) begin
                        m_h[i] = {m_buf[4*i], m_buf[4*i+1]};
                        m_v[i] = {m_buf[4*i+2], m_buf[4*i+3]};
                    end
                    exp_v = 1;
                    m_pcnt = m_pcnt + 1;
                    m_pos = 0;
                end
            end else begin
                model_err();
                m_pos = (b == 8'h53) ? 1 : 0;
            end
        end else if (m_pos != 0) begin
            m_gap++;
            if (m_gap == T - 1) begin
                model_err();
                m_pos = 0;
                m_gap = 0;
            end
        end
    endtask

    task automatic compare_all();
        seen_v |= PKT_VALID;
        seen_e |= PKT_ERR;
        chk("pkt_valid", {31'd0, PKT_VALID}, {31'd0, exp_v});
        chk("pkt_err", {31'd0, PKT_ERR}, {31'd0, exp_e});
        chk("pkt_cnt", {16'd0, PKT_CNT}, {16'd0, m_pcnt});
        chk("err_cnt", {24'd0, ERR_CNT}, {24'd0, m_ecnt});
        for (int i = 0; i < 8; i++)
            chk($sformatf("points_%0d", i), {ph[i], pv[i]}, {m_h[i], m_v[i]});
    endtask

    task automatic tick(input bit dv, input logic [7:0] b);
        RX_DV = dv; RX_BYTE = b;
        @(posedge CLK); #1;
        RX_DV = 0; RX_BYTE = 0;
        model_step(dv, b);
        compare_all();
    endtask

    // RX_DV is held high during reset to show it is ignored.
    task automatic do_reset();
        RESET = 1; RX_DV = 1; RX_BYTE = 8'h53;
        @(posedge CLK); #1;
        RESET = 0; RX_DV = 0; RX_BYTE = 0;
        model_reset();
        compare_all();
    endtask

    task automatic send_frame();
        logic [7:0] b;
        tick(1, 8'h53);
        tick(1, 8'h54);
        for (int k = 0; k < 32; k++) begin
            case (k % 4)
                0: b = fh[k/4][15:8];
                1: b = fh[k/4][7:0];
                2: b = fv[k/4][15:8];
                default: b = fv[k/4][7:0];
            endcase
            tick(1, b);
            if (k == gap_at) repeat (gap_len) tick(0, 8'h00);
        end
        for (int j = 0; j < 3; j++) tick(1, ft[j]);
    endtask

    task automatic set_pts(input logic [15:0] hb, input logic [15:0] vb);
        for (int n = 0; n < 8; n++) begin fh[n] = hb + 16'(n); fv[n] = vb + 16'(n); end
        ft[0] = 8'h45; ft[1] = 8'h4E; ft[2] = 8'h44;
        gap_at = -1; gap_len = 0;
    endtask

    initial begin
        int pc0;
        trl[0] = 8'h45; trl[1] = 8'h4E; trl[2] = 8'h44;
        seen_v = 0; seen_e = 0;
        tbl[0] = '{"good",        8'h45, 8'h4E, 8'h44, -1, 0,     1'b1};
        tbl[1] = '{"bad_d",       8'h45, 8'h4E, 8'h58, -1, 0,     1'b0};
        tbl[2] = '{"bad_e_is_s",  8'h53, 8'h4E, 8'h44, -1, 0,     1'b0};
        tbl[3] = '{"gap_t_m2",    8'h45, 8'h4E, 8'h44, 10, T - 2, 1'b1};
        tbl[4] = '{"gap_t_m1",    8'h45, 8'h4E, 8'h44, 10, T - 1, 1'b0};
        tbl[5] = '{"gap_t",       8'h45, 8'h4E, 8'h44, 10, T,     1'b0};

        model_reset();
        repeat (2) do_reset();
        chk("reset_pkt_cnt", {16'd0, PKT_CNT}, 32'd0);
        chk("reset_err_cnt", {24'd0, ERR_CNT}, 32'd0);
        chk("reset_h0", {16'd0, ph[0]}, 32'd0);
        chk("reset_flags", {30'd0, PKT_VALID, PKT_ERR}, 32'd0);

        // Good frame 1.
        set_pts(16'h0100, 16'h0200);
        seen_e = 0;
        send_frame();
        chk("f1_valid_after_d", {31'd0, PKT_VALID}, 32'd1);
        chk("f1_h3", {16'd0, ph[3]}, 32'h0103);
        chk("f1_v7", {16'd0, pv[7]}, 32'h0207);
        chk("f1_pkt_cnt", {16'd0, PKT_CNT}, 32'd1);
        tick(0, 8'h00);
        chk("f1_valid_one_cycle", {31'd0, PKT_VALID}, 32'd0);
        chk("f1_no_err", {31'd0, seen_e}, 32'd0);

        // Bad trailer "ENX": error, points keep frame 1.
        set_pts(16'h0AA0, 16'h0BB0);
        ft[2] = 8'h58;
        seen_v = 0;
        send_frame();
        tick(0, 8'h00);
        chk("enx_err_cnt", {24'd0, ERR_CNT}, 32'd1);
        chk("enx_h3_held", {16'd0, ph[3]}, 32'h0103);
        chk("enx_no_valid", {31'd0, seen_v}, 32'd0);

        // Payload bytes equal to header/trailer codes are plain data.
        set_pts(16'h4544, 16'h5300);
        fh[0] = 16'h5354; fv[0] = 16'h454E;
        send_frame();
        chk("codes_valid", {31'd0, PKT_VALID}, 32'd1);
        chk("codes_h0", {16'd0, ph[0]}, 32'h5354);
        chk("codes_v0", {16'd0, pv[0]}, 32'h454E);

        // Table of frame variants, back to back.
        for (int i = 0; i < 6; i++) begin
            set_pts(16'h1000 + 16'(i * 16), 16'h2000);
            ft[0] = tbl[i].t0; ft[1] = tbl[i].t1; ft[2] = tbl[i].t2;
            gap_at = tbl[i].gat; gap_len = tbl[i].glen;
            pc0 = int'(PKT_CNT);
            seen_v = 0; seen_e = 0;
            send_frame();
            tick(0, 8'h00);
            chk({tbl[i].name, "_valid"}, {31'd0, seen_v}, {31'd0, tbl[i].exp_ok});
            chk({tbl[i].name, "_err"}, {31'd0, seen_e}, {31'd0, !tbl[i].exp_ok});
            chk({tbl[i].name, "_cnt"}, 32'(int'(PKT_CNT) - pc0), {31'd0, tbl[i].exp_ok});
        end

        // Leading noise 0x00,0x53 then frame header gives "S S T".
        pc0 = int'(PKT_CNT);
        tick(1, 8'h00);
        tick(1, 8'h53);
        set_pts(16'h3000, 16'h4000);
        send_frame();
        chk("noise_cnt", 32'(int'(PKT_CNT) - pc0), 32'd1);

        // Reset at payload byte 20, then a fresh frame.
        tick(1, 8'h53);
        tick(1, 8'h54);
        for (int k = 0; k < 20; k++) tick(1, 8'(k));
        seen_e = 0;
        do_reset();
        chk("rst_mid_cnt", {16'd0, PKT_CNT}, 32'd0);
        chk("rst_mid_err", {24'd0, ERR_CNT}, 32'd0);
        chk("rst_mid_h3", {16'd0, ph[3]}, 32'd0);
        set_pts(16'h0500, 16'h0600);
        send_frame();
        chk("rst_next_cnt", {16'd0, PKT_CNT}, 32'd1);
        chk("rst_no_err", {31'd0, seen_e}, 32'd0);

        // Error counter saturation.
        set_pts(16'h0700, 16'h0800);
        ft[1] = 8'h00;
        for (int i = 0; i < 260; i++) send_frame();
        chk("err_sat", {24'd0, ERR_CNT}, 32'hFF);
        chk("err_sat_h0", {16'd0, ph[0]}, 32'h0500);

        // Random traffic: noise, corrupted trailers, gaps near the limit.
        for (int f = 0; f < 100; f++) begin
            int nn;
            nn = int'($urandom_range(0, 2));
            for (int j = 0; j < nn; j++) tick(1, 8'($urandom));
            for (int n = 0; n < 8; n++) begin fh[n] = 16'($urandom); fv[n] = 16'($urandom); end
            ft[0] = 8'h45; ft[1] = 8'h4E; ft[2] = 8'h44;
            if ($urandom_range(0, 4) == 0) ft[$urandom_range(0, 2)] = 8'($urandom);
            gap_at = -1; gap_len = 0;
            if ($urandom_range(0, 5) == 0) begin
                gap_at = int'($urandom_range(0, 31));
                gap_len = T - 3 + int'($urandom_range(0, 3));
            end
            send_frame();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) tick(0, 8'h00);
        end
        repeat (3) tick(0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
